spu_ma_l2req_arb: RTL and testbench
===================================

Name: spu_ma_l2req_arb

Overview:
- Arbitrates the single SPU-to-L2 request port between the modular-arithmetic load engine (ldreq) and the MA store engine (streq).
- Sequences each accepted request through a small grant FSM.
- Routes the L2 accept pulse back to the winning requester.
- Tracks outstanding loads and stores per type, and throttles each type at a configurable limit.

Parameters:
MAX_OUTST, 2, maximum outstanding requests per type (1..2^CNT_W-1)
CNT_W, 2, width of each outstanding counter

Ports:
rclk  in  1  clock
arst_l  in  1  asynchronous active-low reset
se  in  1  scan enable, no functional effect
mald_ldreq  in  1  load request level, held until ldreq_ack
mast_streq  in  1  store request level, held until streq_ack
ldreq_ack  out  1  one-cycle accept pulse to load engine
streq_ack  out  1  one-cycle accept pulse to store engine
spu_l2_req_vld  out  1  request valid to L2 interface
spu_l2_req_st  out  1  request type: 0 = load, 1 = store; valid with spu_l2_req_vld
l2_spu_req_ack  in  1  L2 accepts the presented request (pulse)
l2_spu_ld_rtn  in  1  load line returned, retires one load (pulse)
l2_spu_st_ack  in  1  store completed, retires one store (pulse)
ma_abort  in  1  synchronous flush (MA unc error / stxa force abort)
ld_outst  out  CNT_W  outstanding load count
st_outst  out  CNT_W  outstanding store count
arb_busy  out  1  FSM not IDLE or any count nonzero
arb_cnt_err  out  1  sticky: retire pulse received at count 0

Behaviour:
- Reset (arst_l low, async):
  - state = IDLE; all outputs 0; counters 0; arb_cnt_err 0.
  - last_gnt = store, so load wins the first tie.
- FSM states: IDLE, LD_REQ, ST_REQ (one-hot or encoded; registered).
- Eligibility, evaluated in IDLE:
  - ld_elig = mald_ldreq & (ld_outst < MAX_OUTST)
  - st_elig = mast_streq & (st_outst < MAX_OUTST)
- IDLE transitions:
  - only ld_elig -> LD_REQ.
  - only st_elig -> ST_REQ.
  - both -> the type opposite last_gnt (round robin).
  - neither -> stay IDLE.
- spu_l2_req_vld = (state != IDLE), driven from the state register. spu_l2_req_st = (state == ST_REQ).
- Latency: request visible on the L2 port 1 cycle after the eligible request is sampled in IDLE.
- LD_REQ/ST_REQ: hold vld and type stable until l2_spu_req_ack. There is no timeout.
- On l2_spu_req_ack in LD_REQ (same cycle):
  - ldreq_ack = 1 (combinational, same cycle as l2_spu_req_ack).
  - next state IDLE.
  - last_gnt <= load.
  - ld_outst increments next edge.
  - ST_REQ is symmetric (streq_ack, st_outst, last_gnt <= store).
- Mandatory IDLE bubble: after every accept the FSM spends ≥1 cycle in IDLE. Requesters drop their level the cycle after the ack, so there is no double grant.
- Requests are non-retractable. If a requester drops its level while in its REQ state, the arbiter keeps presenting the request until ack or abort.
- Counters:
  - +1 on accept.
  - -1 on matching retire pulse (l2_spu_ld_rtn for loads, l2_spu_st_ack for stores).
  - Accept and retire in the same cycle -> count unchanged.
  - Retire at count 0 -> count stays 0 and arb_cnt_err is set. The error flag clears only on reset.
  - Overflow is impossible by eligibility gating.
- ma_abort (synchronous, highest priority):
  - next state IDLE; both counters 0.
  - An l2_spu_req_ack in the same cycle produces no ldreq_ack/streq_ack and no increment.
  - vld drops the next cycle.
  - last_gnt is unchanged; arb_cnt_err is unchanged.
- arb_busy is combinational from the state and counters.
- A retire pulse in the same cycle as ma_abort is ignored.

Test Plan:
- Reset, then mald_ldreq=1 only: vld=1, st=0 at cycle+1; ack at cycle+3 -> ldreq_ack pulse that same cycle, ld_outst=1, state IDLE at cycle+4.
- Both requests held continuously, L2 acks each request 1 cycle after it appears, retire pulses keep counts below MAX: grant order ld, st, ld, st; exactly one bubble cycle between grants.
- MAX_OUTST=2, two loads accepted, no returns, mald_ldreq held: no third vld. An l2_spu_ld_rtn pulse -> ld_outst=1 -> new load request one cycle after the count update.
- Accept and l2_spu_ld_rtn in the same cycle with ld_outst=1 -> ld_outst stays 1. l2_spu_st_ack with st_outst=0 -> arb_cnt_err=1, st_outst=0.
- In ST_REQ, raise ma_abort together with l2_spu_req_ack, ld_outst=2 -> streq_ack=0, next cycle vld=0, ld_outst=0, st_outst=0, state IDLE.
- Assert arst_l low mid-LD_REQ, asynchronously between clock edges -> vld and counts go to 0 immediately, before the next edge. After release, the first tie is granted to load.

Source files
------------

// File: rtl/spu_ma_l2req_arb.sv
// rtl/spu_ma_l2req_arb.sv - SPU MA load/store arbiter for the shared L2 request port
module spu_ma_l2req_arb #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             se,
    input  logic             mald_ldreq,
    input  logic             mast_streq,
    output logic             ldreq_ack,
    output logic             streq_ack,
    output logic             spu_l2_req_vld,
    output logic             spu_l2_req_st,
    input  logic             l2_spu_req_ack,
    input  logic             l2_spu_ld_rtn,
    input  logic             l2_spu_st_ack,
    input  logic             ma_abort,
    output logic [CNT_W-1:0] ld_outst,
    output logic [CNT_W-1:0] st_outst,
    output logic             arb_busy,
    output logic             arb_cnt_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_REQ = 2'd1,
        ST_REQ = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    state_t     state;
    state_t     state_nxt;
    logic       last_gnt_st;
    logic       ld_elig;
    logic       st_elig;
    logic       ld_rtn;
    logic       st_rtn;
    logic       unused_se;

    // Scan enable has no functional role in this block.
    assign unused_se = se;

    assign ld_elig = mald_ldreq & (ld_outst < MAX_C);
    assign st_elig = mast_streq & (st_outst < MAX_C);

    // Accept pulses are routed straight through from L2; an abort in the same cycle squashes them.
    assign ldreq_ack = (state == LD_REQ) & l2_spu_req_ack & ~ma_abort;
    assign streq_ack = (state == ST_REQ) & l2_spu_req_ack & ~ma_abort;

    // Retires coinciding with an abort are dropped because the counters are being flushed anyway.
    assign ld_rtn = l2_spu_ld_rtn & ~ma_abort;
    assign st_rtn = l2_spu_st_ack & ~ma_abort;

    assign spu_l2_req_vld = (state != IDLE);
    assign spu_l2_req_st  = (state == ST_REQ);
    assign arb_busy       = (state != IDLE) | (ld_outst != '0) | (st_outst != '0);

    // Grant state register.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: round-robin tie break in IDLE, hold the request until L2 accepts or abort.
    always_comb begin
        state_nxt = state;
        if (ma_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_elig && st_elig) begin
                        state_nxt = last_gnt_st ? LD_REQ : ST_REQ;
                    end else if (ld_elig) begin
                        state_nxt = LD_REQ;
                    end else if (st_elig) begin
                        state_nxt = ST_REQ;
                    end
                end
                LD_REQ, ST_REQ: begin
                    if (l2_spu_req_ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Remember which type was last accepted; starts as store so load wins the first tie.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            last_gnt_st <= 1'b1;
        end else if (ldreq_ack) begin
            last_gnt_st <= 1'b0;
        end else if (streq_ack) begin
            last_gnt_st <= 1'b1;
        end
    end

    // Outstanding load counter; an accept and a retire in the same cycle cancel out.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ld_outst <= '0;
        end else if (ma_abort) begin
            ld_outst <= '0;
        end else if (ldreq_ack && !ld_rtn) begin
            ld_outst <= ld_outst + 1'b1;
        end else if (!ldreq_ack && ld_rtn && (ld_outst != '0)) begin
            ld_outst <= ld_outst - 1'b1;
        end
    end

    // Outstanding store counter, same rules as loads.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            st_outst <= '0;
        end else if (ma_abort) begin
            st_outst <= '0;
        end else if (streq_ack && !st_rtn) begin
            st_outst <= st_outst + 1'b1;
        end else if (!streq_ack && st_rtn && (st_outst != '0)) begin
            st_outst <= st_outst - 1'b1;
        end
    end

    // Sticky flag for a retire arriving when nothing of that type is outstanding.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            arb_cnt_err <= 1'b0;
        end else if ((ld_rtn && !ldreq_ack && (ld_outst == '0)) ||
                     (st_rtn && !streq_ack && (st_outst == '0))) begin
            arb_cnt_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spu_ma_l2req_arb.sv
// tb/tb_spu_ma_l2req_arb.sv - directed self-checking bench for spu_ma_l2req_arb
module tb_spu_ma_l2req_arb;

    logic       rclk;
    logic       arst_l;
    logic       se;
    logic       mald_ldreq;
    logic       mast_streq;
    logic       ldreq_ack;
    logic       streq_ack;
    logic       spu_l2_req_vld;
    logic       spu_l2_req_st;
    logic       l2_spu_req_ack;
    logic       l2_spu_ld_rtn;
    logic       l2_spu_st_ack;
    logic       ma_abort;
    logic [1:0] ld_outst;
    logic [1:0] st_outst;
    logic       arb_busy;
    logic       arb_cnt_err;

    int tests_run;
    int tests_failed;

    spu_ma_l2req_arb #(.MAX_OUTST(2), .CNT_W(2)) dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .se             (se),
        .mald_ldreq     (mald_ldreq),
        .mast_streq     (mast_streq),
        .ldreq_ack      (ldreq_ack),
        .streq_ack      (streq_ack),
        .spu_l2_req_vld (spu_l2_req_vld),
        .spu_l2_req_st  (spu_l2_req_st),
        .l2_spu_req_ack (l2_spu_req_ack),
        .l2_spu_ld_rtn  (l2_spu_ld_rtn),
        .l2_spu_st_ack  (l2_spu_st_ack),
        .ma_abort       (ma_abort),
        .ld_outst       (ld_outst),
        .st_outst       (st_outst),
        .arb_busy       (arb_busy),
        .arb_cnt_err    (arb_cnt_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        arst_l         = 1'b0;
        se             = 1'b0;
        mald_ldreq     = 1'b0;
        mast_streq     = 1'b0;
        l2_spu_req_ack = 1'b0;
        l2_spu_ld_rtn  = 1'b0;
        l2_spu_st_ack  = 1'b0;
        ma_abort       = 1'b0;
        step();
        step();
        arst_l = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        #2;
        tests_run++;
        if ({spu_l2_req_vld, spu_l2_req_st, ldreq_ack, streq_ack, ld_outst, st_outst, arb_busy, arb_cnt_err} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b exp=0", {spu_l2_req_vld, spu_l2_req_st, ldreq_ack, streq_ack, ld_outst, st_outst, arb_busy, arb_cnt_err});
        end
        do_reset();
    endtask

    task automatic test_single_load();
        do_reset();
        mald_ldreq = 1'b1;
        step();
        tests_run++;
        if ({spu_l2_req_vld, spu_l2_req_st} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_vld got vld/st=%b exp=10", {spu_l2_req_vld, spu_l2_req_st});
        end
        step();
        l2_spu_req_ack = 1'b1;
        #1;
        tests_run++;
        if (ldreq_ack !== 1'b1 || streq_ack !== 1'b0 || ld_outst !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_ack got ld_ack=%b st_ack=%b ld_outst=%0d exp 1 0 0", ldreq_ack, streq_ack, ld_outst);
        end
        step();
        l2_spu_req_ack = 1'b0;
        mald_ldreq     = 1'b0;
        #1;
        tests_run++;
        if (spu_l2_req_vld !== 1'b0 || ld_outst !== 2'd1 || ldreq_ack !== 1'b0 || arb_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_after got vld=%b ld_outst=%0d ack=%b busy=%b exp 0 1 0 1", spu_l2_req_vld, ld_outst, ldreq_ack, arb_busy);
        end
        l2_spu_ld_rtn = 1'b1;
        step();
        l2_spu_ld_rtn = 1'b0;
        #1;
        tests_run++;
        if (ld_outst !== 2'd0 || arb_busy !== 1'b0 || arb_cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_retire got ld_outst=%0d busy=%b err=%b exp 0 0 0", ld_outst, arb_busy, arb_cnt_err);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mald_ldreq = 1'b1;
        mast_streq = 1'b1;
        step();
        for (int g = 0; g < 4; g++) begin
            tests_run++;
            if (spu_l2_req_vld !== 1'b1 || spu_l2_req_st !== g[0]) begin
                tests_failed++;
                $display("FAIL rr_grant%0d got vld=%b st=%b exp 1 %b", g, spu_l2_req_vld, spu_l2_req_st, g[0]);
            end
            step();
            l2_spu_req_ack = 1'b1;
            #1;
            tests_run++;
            if ({ldreq_ack, streq_ack} !== (g[0] ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL rr_ack%0d got ld/st ack=%b exp %b", g, {ldreq_ack, streq_ack}, (g[0] ? 2'b01 : 2'b10));
            end
            step();
            l2_spu_req_ack = 1'b0;
            if (g[0]) l2_spu_st_ack = 1'b1;
            else      l2_spu_ld_rtn = 1'b1;
            if (g == 3) begin
                mald_ldreq = 1'b0;
                mast_streq = 1'b0;
            end
            #1;
            tests_run++;
            if (spu_l2_req_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_bubble%0d got vld=%b exp 0", g, spu_l2_req_vld);
            end
            step();
            l2_spu_ld_rtn = 1'b0;
            l2_spu_st_ack = 1'b0;
        end
        #1;
        tests_run++;
        if (ld_outst !== 2'd0 || st_outst !== 2'd0 || spu_l2_req_vld !== 1'b0 || arb_cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_end got ld=%0d st=%0d vld=%b err=%b exp 0 0 0 0", ld_outst, st_outst, spu_l2_req_vld, arb_cnt_err);
        end
    endtask

    task automatic test_throttle_and_same_cycle();
        do_reset();
        mald_ldreq = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            l2_spu_req_ack = 1'b1;
            step();
            l2_spu_req_ack = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (spu_l2_req_vld !== 1'b0 || ld_outst !== 2'd2) begin
                tests_failed++;
                $display("FAIL throttle_hold%0d got vld=%b ld_outst=%0d exp 0 2", k, spu_l2_req_vld, ld_outst);
            end
            step();
        end
        l2_spu_ld_rtn = 1'b1;
        step();
        l2_spu_ld_rtn = 1'b0;
        #1;
        tests_run++;
        if (spu_l2_req_vld !== 1'b0 || ld_outst !== 2'd1) begin
            tests_failed++;
            $display("FAIL throttle_rtn got vld=%b ld_outst=%0d exp 0 1", spu_l2_req_vld, ld_outst);
        end
        step();
        tests_run++;
        if (spu_l2_req_vld !== 1'b1 || spu_l2_req_st !== 1'b0) begin
            tests_failed++;
            $display("FAIL throttle_resume got vld=%b st=%b exp 1 0", spu_l2_req_vld, spu_l2_req_st);
        end
        l2_spu_req_ack = 1'b1;
        l2_spu_ld_rtn  = 1'b1;
        step();
        l2_spu_req_ack = 1'b0;
        l2_spu_ld_rtn  = 1'b0;
        mald_ldreq     = 1'b0;
        #1;
        tests_run++;
        if (ld_outst !== 2'd1 || arb_cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle got ld_outst=%0d err=%b exp 1 0", ld_outst, arb_cnt_err);
        end
        l2_spu_st_ack = 1'b1;
        step();
        l2_spu_st_ack = 1'b0;
        #1;
        tests_run++;
        if (arb_cnt_err !== 1'b1 || st_outst !== 2'd0 || arb_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL cnt_err got err=%b st_outst=%0d busy=%b exp 1 0 1", arb_cnt_err, st_outst, arb_busy);
        end
    endtask

    task automatic test_abort();
        do_reset();
        mald_ldreq = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            l2_spu_req_ack = 1'b1;
            step();
            l2_spu_req_ack = 1'b0;
        end
        mald_ldreq = 1'b0;
        mast_streq = 1'b1;
        step();
        tests_run++;
        if (spu_l2_req_vld !== 1'b1 || spu_l2_req_st !== 1'b1 || ld_outst !== 2'd2) begin
            tests_failed++;
            $display("FAIL abort_setup got vld=%b st=%b ld_outst=%0d exp 1 1 2", spu_l2_req_vld, spu_l2_req_st, ld_outst);
        end
        l2_spu_req_ack = 1'b1;
        ma_abort       = 1'b1;
        #1;
        tests_run++;
        if (streq_ack !== 1'b0 || ldreq_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ack got st_ack=%b ld_ack=%b exp 0 0", streq_ack, ldreq_ack);
        end
        step();
        l2_spu_req_ack = 1'b0;
        ma_abort       = 1'b0;
        mast_streq     = 1'b0;
        #1;
        tests_run++;
        if (spu_l2_req_vld !== 1'b0 || ld_outst !== 2'd0 || st_outst !== 2'd0 || arb_busy !== 1'b0 || arb_cnt_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_after got vld=%b ld=%0d st=%0d busy=%b err=%b exp 0 0 0 0 0", spu_l2_req_vld, ld_outst, st_outst, arb_busy, arb_cnt_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mald_ldreq = 1'b1;
        step();
        l2_spu_req_ack = 1'b1;
        step();
        l2_spu_req_ack = 1'b0;
        step();
        tests_run++;
        if (spu_l2_req_vld !== 1'b1 || ld_outst !== 2'd1) begin
            tests_failed++;
            $display("FAIL arst_setup got vld=%b ld_outst=%0d exp 1 1", spu_l2_req_vld, ld_outst);
        end
        #2;
        arst_l = 1'b0;
        #1;
        tests_run++;
        if (spu_l2_req_vld !== 1'b0 || ld_outst !== 2'd0 || arb_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_async got vld=%b ld_outst=%0d busy=%b exp 0 0 0", spu_l2_req_vld, ld_outst, arb_busy);
        end
        step();
        arst_l     = 1'b1;
        mald_ldreq = 1'b1;
        mast_streq = 1'b1;
        step();
        tests_run++;
        if (spu_l2_req_vld !== 1'b1 || spu_l2_req_st !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_first_tie got vld=%b st=%b exp 1 0", spu_l2_req_vld, spu_l2_req_st);
        end
        mald_ldreq = 1'b0;
        mast_streq = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        do_reset();
        test_reset();
        test_single_load();
        test_round_robin();
        test_throttle_and_same_cycle();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
